// File: rtl/pcm_slot_tx_pkg.sv
// Shared definitions for the PCM slot transmitter and its strobe source:
// state encoding, default geometry and a clog2 helper.
package pcm_pkg;

  // Bits per slot; matches the strobe generator's strobe-high length.
  localparam int PCM_WIDTH = 8;
  // Width of the slot counter.
  localparam int PCM_CNT_W = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } pcm_state_e;

  // Smallest n with 2**n >= v (returns 0 for v <= 1).
  function automatic int pcm_clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pcm_slot_tx_if.sv
// Word input handshake of the slot transmitter.
// valid/ready: a word transfers on every rising clk edge where in_valid and
// in_ready are both high; in_data must be stable while in_valid is high and
// in_ready does not depend on in_valid.
interface pcm_slot_tx_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/pcm_slot_tx_fifo.sv
// Small synchronous show-ahead FIFO. Writes while full and reads while empty
// are ignored; level is kept as its own counter so pointers wrap freely.
module pcm_sync_fifo
  import pcm_pkg::*;
#(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [W-1:0]          wr_data,
  input  logic                  rd_en,
  output logic [W-1:0]          rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [pcm_clog2(D):0] level
);

  localparam int AW = pcm_clog2(D);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(D);

  logic [W-1:0]  r_mem [D];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          w_do_wr;
  logic          w_do_rd;

  assign full    = (r_level == LVL_FULL);
  assign empty   = (r_level == '0);
  assign level   = r_level;
  assign rd_data = r_mem[r_rd_ptr];
  assign w_do_wr = wr_en & ~full;
  assign w_do_rd = rd_en & ~empty;

  // Storage write; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr] <= wr_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_wr, w_do_rd})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/pcm_slot_tx.sv
// PCM slot transmitter: each rising edge of strb opens a slot in which one
// FIFO word is shifted out MSB first on sdo, framed by sdo_en. An empty FIFO
// at slot start sends idle bits and pulses underrun; a new slot arriving while
// the previous one is still shifting abandons it and pulses frame_err.
module pcm_slot_tx
  import pcm_pkg::*;
#(
  parameter int   WIDTH      = PCM_WIDTH,
  parameter int   FIFO_DEPTH = 4,
  parameter logic IDLE_BIT   = 1'b0,
  parameter int   CNT_W      = PCM_CNT_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           strb,
  pcm_slot_tx_if.slave                   in_if,
  output logic                           sdo,
  output logic                           sdo_en,
  output logic [pcm_clog2(FIFO_DEPTH):0] fifo_level,
  output logic                           underrun,
  output logic                           frame_err,
  output logic [CNT_W-1:0]               frame_cnt,
  output pcm_state_e                     dbg_state
);

  localparam int BW = pcm_clog2(WIDTH);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  logic             r_strb_q;
  pcm_state_e       r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [BW-1:0]    r_bitcnt;
  logic             r_sdo;
  logic             r_sdo_en;
  logic             r_underrun;
  logic             r_frame_err;
  logic [CNT_W-1:0] r_frame_cnt;

  logic             w_start;
  logic             w_empty;
  logic             w_full;
  logic [WIDTH-1:0] w_head;
  logic [WIDTH-1:0] w_load_word;

  // A slot opens on the clk edge that first sees strb high.
  assign w_start     = strb & ~r_strb_q;
  assign w_load_word = w_empty ? {WIDTH{IDLE_BIT}} : w_head;
  assign in_if.in_ready = ~w_full;

  pcm_sync_fifo #(
    .W (WIDTH),
    .D (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (in_if.in_valid),
    .wr_data (in_if.in_data),
    .rd_en   (w_start),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .level   (fifo_level)
  );

  // Slot FSM with shift register, bit counter, flags and slot counter.
  // A slot start takes priority over the end-of-slot return to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_strb_q    <= 1'b0;
      r_state     <= ST_IDLE;
      r_shreg     <= '0;
      r_bitcnt    <= '0;
      r_sdo       <= 1'b0;
      r_sdo_en    <= 1'b0;
      r_underrun  <= 1'b0;
      r_frame_err <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_strb_q    <= strb;
      r_underrun  <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_start) begin
        r_frame_err <= (r_state == ST_SHIFT);
        r_underrun  <= w_empty;
        r_sdo       <= w_load_word[WIDTH-1];
        r_shreg     <= {w_load_word[WIDTH-2:0], 1'b0};
        r_bitcnt    <= BIT_LAST;
        r_sdo_en    <= 1'b1;
        r_state     <= ST_SHIFT;
        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      end else if (r_state == ST_SHIFT) begin
        if (r_bitcnt == '0) begin
          r_state  <= ST_IDLE;
          r_sdo    <= 1'b0;
          r_sdo_en <= 1'b0;
        end else begin
          r_sdo    <= r_shreg[WIDTH-1];
          r_shreg  <= {r_shreg[WIDTH-2:0], 1'b0};
          r_bitcnt <= r_bitcnt - BW'(1);
        end
      end
    end
  end

  assign sdo       = r_sdo;
  assign sdo_en    = r_sdo_en;
  assign underrun  = r_underrun;
  assign frame_err = r_frame_err;
  assign frame_cnt = r_frame_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_pcm_slot_tx.sv
// Bench for pcm_slot_tx. The driver applies one input vector per clock and
// advances a reference model (word queue + per-slot bit list); the model's
// predictions are pushed into stamped queues, and a monitor on the falling
// edge pops and compares them against the DUT outputs.
module tb_pcm_slot_tx;
  import pcm_pkg::*;

  localparam int   WIDTH = 8;
  localparam int   DEPTH = 4;
  localparam logic IDLE  = 1'b0;

  typedef struct {
    int stamp;
    int level;
    int rdy;
    int cnt;
    int cnt4;
  } st_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic strb = 1'b0;
  always #5 clk = ~clk;

  pcm_slot_tx_if #(.WIDTH(WIDTH)) bus ();
  pcm_slot_tx_if #(.WIDTH(WIDTH)) bus4 ();

  logic             sdo, sdo_en, underrun, frame_err;
  logic [2:0]       fifo_level;
  logic [15:0]      frame_cnt;
  pcm_state_e       dbg_state;
  logic             sdo4, sdo_en4, underrun4, frame_err4;
  logic [2:0]       fifo_level4;
  logic [3:0]       frame_cnt4;
  pcm_state_e       dbg_state4;

  pcm_slot_tx #(.WIDTH(WIDTH), .FIFO_DEPTH(DEPTH), .IDLE_BIT(IDLE), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .strb(strb), .in_if(bus),
    .sdo(sdo), .sdo_en(sdo_en), .fifo_level(fifo_level),
    .underrun(underrun), .frame_err(frame_err), .frame_cnt(frame_cnt),
    .dbg_state(dbg_state)
  );

  // Narrow-counter instance: sees the same strobe, used to reach counter wrap.
  pcm_slot_tx #(.WIDTH(WIDTH), .FIFO_DEPTH(DEPTH), .IDLE_BIT(IDLE), .CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .strb(strb), .in_if(bus4),
    .sdo(sdo4), .sdo_en(sdo_en4), .fifo_level(fifo_level4),
    .underrun(underrun4), .frame_err(frame_err4), .frame_cnt(frame_cnt4),
    .dbg_state(dbg_state4)
  );

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];   // {stamp, expected sdo bit} for each sdo_en cycle
  int          uf_q[$];    // stamps of expected underrun pulses
  int          fe_q[$];    // stamps of expected frame_err pulses
  st_t         st_q[$];    // per-cycle expected level / ready / counters

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // reference model
  logic [WIDTH-1:0] m_fifo[$];
  logic [WIDTH-1:0] m_word;
  logic             m_prev = 1'b0;
  logic             m_shifting = 1'b0;
  int               m_idx = WIDTH;
  int unsigned      m_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Model of one clock edge with the given inputs; predictions become
  // visible in the cycle after the edge (stamp = cyc + 1).
  task automatic model_edge(input logic r, input logic s, input logic v,
                            input logic [WIDTH-1:0] d);
    int   stamp;
    logic accept, start, pushed;
    st_t  st;
    stamp  = cyc + 1;
    pushed = 1'b0;
    if (r) begin
      m_fifo.delete();
      m_prev = 1'b0;
      m_idx  = WIDTH;
      m_cnt  = 0;
    end else begin
      accept = v && (m_fifo.size() < DEPTH);
      start  = s && !m_prev;
      m_prev = s;
      if (start) begin
        if (m_shifting) fe_q.push_back(stamp);
        if (m_fifo.size() > 0) m_word = m_fifo.pop_front();
        else begin
          m_word = {WIDTH{IDLE}};
          uf_q.push_back(stamp);
        end
        m_idx = 0;
        m_cnt++;
      end
      if (accept) m_fifo.push_back(d);
      if (m_idx < WIDTH) begin
        exp_q.push_back({stamp[30:0], m_word[WIDTH-1-m_idx]});
        m_idx++;
        pushed = 1'b1;
      end
    end
    m_shifting = pushed;
    st.stamp = stamp;
    st.level = m_fifo.size();
    st.rdy   = (m_fifo.size() < DEPTH) ? 1 : 0;
    st.cnt   = int'(m_cnt % 65536);
    st.cnt4  = int'(m_cnt % 16);
    st_q.push_back(st);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic r, input logic s, input logic v,
                      input logic [WIDTH-1:0] d);
    @(negedge clk);
    rst          = r;
    strb         = s;
    bus.in_valid = v;
    bus.in_data  = d;
    model_edge(r, s, v, d);
    @(posedge clk);
    cyc++;
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    step(1'b0, 1'b0, 1'b1, d);
  endtask

  task automatic frame(input int hi, input int lo);
    for (int i = 0; i < hi; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < lo; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  // ---------------- monitor ----------------
  initial begin
    st_t  st;
    logic exp_en, exp_uf, exp_fe;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        if (st_q.size() > 0 && st_q[0].stamp == cyc) begin
          st = st_q.pop_front();
          check("fifo_level", int'(fifo_level), st.level);
          check("in_ready", int'(bus.in_ready), st.rdy);
          check("frame_cnt", int'(frame_cnt), st.cnt);
          check("frame_cnt_w4", int'(frame_cnt4), st.cnt4);
        end
        exp_en = (exp_q.size() > 0) && (int'(exp_q[0][31:1]) == cyc);
        check("sdo_en", int'(sdo_en), int'(exp_en));
        if (exp_en) begin
          e = exp_q.pop_front();
          check("sdo", int'(sdo), int'(e[0]));
        end else begin
          check("sdo_idle", int'(sdo), 0);
        end
        exp_uf = (uf_q.size() > 0) && (uf_q[0] == cyc);
        if (exp_uf) void'(uf_q.pop_front());
        check("underrun", int'(underrun), int'(exp_uf));
        exp_fe = (fe_q.size() > 0) && (fe_q[0] == cyc);
        if (exp_fe) void'(fe_q.pop_front());
        check("frame_err", int'(frame_err), int'(exp_fe));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int hi, lo;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus4.in_valid = 1'b0;
    bus4.in_data  = '0;

    // reset with strb already high: a slot must open right after reset
    step(1'b1, 1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    frame(8, 8);

    // single word A5
    push(8'hA5);
    frame(8, 12);

    // five pushes into a 4-deep FIFO, then drain plus one underrun slot
    push(8'h01); push(8'h02); push(8'h03); push(8'h04); push(8'h05);
    for (int f = 0; f < 5; f++) frame(8, 10);

    // re-sync 3 cycles into a slot
    push(8'hC3); push(8'h5A);
    frame(3, 1);
    frame(8, 12);

    // reset 4 bits into an FF slot, strb still high at reset
    push(8'hFF);
    frame(4, 0);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);

    // push on the rising strb cycle with an empty FIFO
    step(1'b0, 1'b1, 1'b1, 8'h3C);
    frame(7, 10);
    frame(8, 10);

    // full FIFO with same-cycle pop and refused push
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    step(1'b0, 1'b1, 1'b1, 8'h77);
    frame(7, 10);
    for (int f = 0; f < 4; f++) frame(8, 10);

    // randomized frames, pushes and occasional resets
    for (int f = 0; f < 160; f++) begin
      hi = $urandom_range(1, 10);
      lo = $urandom_range(1, 12);
      for (int i = 0; i < hi + lo; i++) begin
        step(($urandom_range(0, 399) == 0), (i < hi),
             ($urandom_range(0, 2) != 0), WIDTH'($urandom));
      end
    end

    // drain
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("uf_q_drained", uf_q.size(), 0);
    check("fe_q_drained", fe_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
